// File: rtl/spu_dual_issue.sv
// Dual-issue dispatch stage: buffers decoded instruction pairs and steers them in order
// to the even/odd pipes, holding any instruction whose pipe reports a RAW hazard.
module spu_dual_issue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:69]            in0_instr,
  input  logic [0:69]            in1_instr,
  input  logic                   in0_vld,
  input  logic                   in1_vld,
  input  logic                   branch_taken,
  input  logic                   stall_even_raw,
  input  logic                   stall_odd_raw,
  output logic [0:23]            even_src_addr,
  output logic [0:23]            odd_src_addr,
  output logic [0:2]             even_src_vld,
  output logic [0:2]             odd_src_vld,
  output logic [0:69]            even_instr,
  output logic [0:69]            odd_instr,
  output logic                   even_issue,
  output logic                   odd_issue,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_PAIR = 1'b0, S_SECOND = 1'b1} state_t;

  state_t        state, state_nxt;
  // NOTE: pair storage is not reset; count alone decides which entries are live.
  logic [0:69]   mem0   [DEPTH];
  logic [0:69]   mem1   [DEPTH];
  logic          mem1_v [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          flush, push, pop, has_head, pair_ok;
  logic          s0_stall, s1_stall, issue0, issue1;
  logic [0:69]   h0, h1;
  logic          h1_v;
  logic [0:69]   even_cand, odd_cand;

  // Producer rt (7 bits) is zero-extended against the 8-bit consumer source fields.
  function automatic logic raw_hit(input logic [6:0] rt, input logic wr,
                                   input logic [0:23] src, input logic [0:2] sv);
    logic [7:0] rt8;
    rt8 = {1'b0, rt};
    return wr & ((sv[0] & (src[0:7] == rt8)) |
                 (sv[1] & (src[8:15] == rt8)) |
                 (sv[2] & (src[16:23] == rt8)));
  endfunction

  assign flush    = reset | branch_taken;
  assign in_ready = (count != FULL) & !reset;
  assign push     = in_valid & in_ready & (in0_vld | in1_vld) & !branch_taken;

  assign h0       = mem0[rd_ptr];
  assign h1       = mem1[rd_ptr];
  assign h1_v     = mem1_v[rd_ptr];
  assign has_head = (count != '0) & !reset;
  assign pair_ok  = h1_v & (h0[16] != h1[16]) &
                    !raw_hit(h0[17:23], h0[24], h1[25:48], h1[49:51]);
  assign s0_stall = h0[16] ? stall_odd_raw : stall_even_raw;
  assign s1_stall = h1[16] ? stall_odd_raw : stall_even_raw;

  // A lone younger slot is compacted into slot0 so the head always starts at slot0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wr_ptr]   <= in0_vld ? in0_instr : in1_instr;
      mem1[wr_ptr]   <= in1_instr;
      mem1_v[wr_ptr] <= in0_vld & in1_vld;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (flush) state <= S_PAIR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_PAIR:   if (issue0 && !issue1 && h1_v) state_nxt = S_SECOND;
      S_SECOND: if (issue1) state_nxt = S_PAIR;
      default:  state_nxt = S_PAIR;
    endcase
  end

  // Candidates ignore the stall inputs, since the stalls are computed from these sources.
  // NOTE: every output gets a default first so no latch is inferred on uncovered paths.
  always_comb begin
    issue0    = 1'b0;
    issue1    = 1'b0;
    even_cand = '0;
    odd_cand  = '0;
    if (has_head) begin
      if (state == S_PAIR) begin
        if (h0[16]) odd_cand = h0;
        else        even_cand = h0;
        if (pair_ok) begin
          if (h1[16]) odd_cand = h1;
          else        even_cand = h1;
        end
        if (!branch_taken && !s0_stall) begin
          issue0 = 1'b1;
          issue1 = pair_ok & !stall_even_raw & !stall_odd_raw;
        end
      end else begin
        if (h1[16]) odd_cand = h1;
        else        even_cand = h1;
        if (!branch_taken && !s1_stall) issue1 = 1'b1;
      end
    end
  end

  assign pop = (state == S_PAIR) ? (issue0 & (issue1 | !h1_v)) : issue1;

  assign even_src_addr = even_cand[25:48];
  assign even_src_vld  = even_cand[49:51];
  assign odd_src_addr  = odd_cand[25:48];
  assign odd_src_vld   = odd_cand[49:51];

  always_ff @(posedge clk) begin
    if (flush) begin
      even_issue <= 1'b0;
      odd_issue  <= 1'b0;
      even_instr <= '0;
      odd_instr  <= '0;
    end else begin
      even_issue <= (issue0 & !h0[16]) | (issue1 & !h1[16]);
      odd_issue  <= (issue0 & h0[16]) | (issue1 & h1[16]);
      even_instr <= (issue0 & !h0[16]) ? h0 : (issue1 & !h1[16]) ? h1 : '0;
      odd_instr  <= (issue0 & h0[16])  ? h0 : (issue1 & h1[16])  ? h1 : '0;
    end
  end

endmodule

// File: tb/tb_spu_dual_issue.sv
// Self-checking bench for spu_dual_issue: vector table for pair steering and latency,
// directed sequences for stall, full and flush, with an in-order issue scoreboard.
module tb_spu_dual_issue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [0:69] in0_instr, in1_instr;
  logic        in0_vld, in1_vld;
  logic        branch_taken, stall_even_raw, stall_odd_raw;
  logic [0:23] even_src_addr, odd_src_addr;
  logic [0:2]  even_src_vld, odd_src_vld;
  logic [0:69] even_instr, odd_instr;
  logic        even_issue, odd_issue;
  logic [$clog2(DEPTH):0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_cyc = -1;
  int last_cyc  = -1;
  logic [0:69] sb[$];

  typedef struct {
    logic [0:69] i0;
    logic [0:69] i1;
    logic        v0;
    logic        v1;
    int          t0;
    int          t1;
  } vec_t;
  vec_t vecs[12];

  spu_dual_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in0_instr(in0_instr), .in1_instr(in1_instr), .in0_vld(in0_vld), .in1_vld(in1_vld),
    .branch_taken(branch_taken), .stall_even_raw(stall_even_raw), .stall_odd_raw(stall_odd_raw),
    .even_src_addr(even_src_addr), .odd_src_addr(odd_src_addr),
    .even_src_vld(even_src_vld), .odd_src_vld(odd_src_vld),
    .even_instr(even_instr), .odd_instr(odd_instr),
    .even_issue(even_issue), .odd_issue(odd_issue), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [0:69] mk(input logic p, input logic [6:0] rt, input logic wr,
                                     input logic [7:0] ra, input logic rav,
                                     input logic [7:0] rb, input logic rbv,
                                     input logic [7:0] rc, input logic rcv,
                                     input logic [10:0] op);
    logic [0:69] w;
    w        = '0;
    w[0:10]  = op;
    w[11:13] = 3'd1;
    w[16]    = p;
    w[17:23] = rt;
    w[24]    = wr;
    w[25:32] = ra;
    w[33:40] = rb;
    w[41:48] = rc;
    w[49]    = rav;
    w[50]    = rbv;
    w[51]    = rcv;
    w[52:69] = {op, 7'h2a};
    return w;
  endfunction

  // Scoreboard holds program order; each issued word must be the oldest outstanding one.
  always @(negedge clk) begin
    logic e_left, o_left;
    logic [0:69] exp_w;
    if (!reset) begin
      e_left = even_issue;
      o_left = odd_issue;
      if (even_issue || odd_issue) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      while (e_left || o_left) begin
        if (sb.size() == 0) begin
          check("unexpected_issue", {68'd0, e_left, o_left}, 70'd0);
          e_left = 1'b0;
          o_left = 1'b0;
        end else begin
          exp_w = sb.pop_front();
          if (exp_w[16]) begin
            check("odd_in_order", {69'd0, o_left}, 70'd1);
            if (o_left) check("odd_instr", odd_instr, exp_w);
            o_left = 1'b0;
          end else begin
            check("even_in_order", {69'd0, e_left}, 70'd1);
            if (e_left) check("even_instr", even_instr, exp_w);
            e_left = 1'b0;
          end
        end
      end
      if (!even_issue) check("even_idle_word", even_instr, 70'd0);
      if (!odd_issue)  check("odd_idle_word", odd_instr, 70'd0);
    end
  end

  // Called just after a rising edge; returns just after the edge that samples the pair.
  task automatic drive_pair(input logic [0:69] i0, input logic [0:69] i1,
                            input logic v0, input logic v1, output int k, output logic acc);
    in0_instr = i0;
    in1_instr = i1;
    in0_vld   = v0;
    in1_vld   = v1;
    in_valid  = 1'b1;
    k = cyc;
    @(negedge clk);
    acc = in_ready;
    if (acc && !branch_taken) begin
      if (v0) sb.push_back(i0);
      if (v1) sb.push_back(i1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in0_vld  = 1'b0;
    in1_vld  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 70'(sb.size()), 70'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int k;
    logic acc;
    logic [0:69] p1a, p1b;

    vecs[0]  = '{mk(0,3,1, 1,1, 2,1, 0,0, 1),  mk(1,4,1, 5,1, 0,0, 0,0, 2),  1, 1, 2, 2};
    vecs[1]  = '{mk(0,10,1, 1,1, 0,0, 0,0, 3), mk(0,11,1, 2,1, 0,0, 0,0, 4), 1, 1, 2, 3};
    vecs[2]  = '{mk(0,7,1, 1,1, 0,0, 0,0, 5),  mk(1,8,1, 7,1, 0,0, 0,0, 6),  1, 1, 2, 3};
    vecs[3]  = '{mk(1,12,1, 0,0, 0,0, 0,0, 7), mk(0,13,1, 0,0, 0,0, 0,0, 8), 1, 1, 2, 2};
    vecs[4]  = '{mk(1,9,1, 0,0, 0,0, 0,0, 9),  mk(0,10,1, 0,0, 0,0, 9,1, 10), 1, 1, 2, 3};
    vecs[5]  = '{mk(0,7,1, 0,0, 0,0, 0,0, 11), mk(1,8,1, 7,0, 7,0, 7,0, 12), 1, 1, 2, 2};
    vecs[6]  = '{mk(0,7,0, 0,0, 0,0, 0,0, 13), mk(1,8,1, 7,1, 0,0, 0,0, 14), 1, 1, 2, 2};
    vecs[7]  = '{mk(0,1,1, 0,0, 0,0, 0,0, 15), mk(1,2,1, 0,0, 0,0, 0,0, 16), 0, 1, 2, 2};
    vecs[8]  = '{mk(0,3,1, 0,0, 0,0, 0,0, 17), mk(1,4,1, 0,0, 0,0, 0,0, 18), 1, 0, 2, 2};
    vecs[9]  = '{mk(1,20,1, 0,0, 0,0, 0,0, 19), mk(1,21,1, 0,0, 0,0, 0,0, 20), 1, 1, 2, 3};
    vecs[10] = '{mk(0,7,1, 0,0, 0,0, 0,0, 21), mk(1,8,1, 8'h87,1, 0,0, 0,0, 22), 1, 1, 2, 2};
    vecs[11] = '{mk(0,20,1, 0,0, 0,0, 0,0, 23), mk(1,21,1, 0,0, 20,1, 0,0, 24), 1, 1, 2, 3};

    reset = 1'b1; branch_taken = 1'b0; stall_even_raw = 1'b0; stall_odd_raw = 1'b0;
    in_valid = 1'b1; in0_vld = 1'b1; in1_vld = 1'b1;
    in0_instr = vecs[0].i0; in1_instr = vecs[0].i1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 70'(in_ready), 70'd0);
    check("rst_count", 70'(count), 70'd0);
    check("rst_issue", {68'd0, even_issue, odd_issue}, 70'd0);
    check("rst_src_vld", {64'd0, even_src_vld, odd_src_vld}, 70'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in0_vld = 1'b0; in1_vld = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 70'(in_ready), 70'd1);
    check("post_rst_count", 70'(count), 70'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      first_cyc = -1;
      drive_pair(vecs[i].i0, vecs[i].i1, vecs[i].v0, vecs[i].v1, k, acc);
      @(negedge clk);
      check($sformatf("v%0d_count_head", i), 70'(count), 70'd1);
      if (i == 0) begin
        check("v0_even_src_addr", 70'(even_src_addr), 70'({8'd1, 8'd2, 8'd0}));
        check("v0_even_src_vld", 70'(even_src_vld), 70'(3'b110));
        check("v0_odd_src_addr", 70'(odd_src_addr), 70'({8'd5, 8'd0, 8'd0}));
        check("v0_odd_src_vld", 70'(odd_src_vld), 70'(3'b100));
      end
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_first_latency", i), 70'(first_cyc - k), 70'(vecs[i].t0));
      check($sformatf("v%0d_last_latency", i), 70'(last_cyc - k), 70'(vecs[i].t1));
      check($sformatf("v%0d_count_empty", i), 70'(count), 70'd0);
      check($sformatf("v%0d_drained", i), 70'(sb.size()), 70'd0);
      @(posedge clk); #1;
    end

    // Even slot0 stalled for three decisions; RAW pair keeps the odd slot behind it.
    first_cyc = -1;
    stall_even_raw = 1'b1;
    drive_pair(mk(0,7,1, 1,1, 2,1, 0,0, 200), mk(1,8,1, 7,1, 0,0, 0,0, 201), 1, 1, k, acc);
    @(negedge clk);
    check("stall_e_even_src_vld", 70'(even_src_vld), 70'(3'b110));
    check("stall_e_odd_src_vld", 70'(odd_src_vld), 70'd0);
    repeat (3) @(posedge clk);
    #1 stall_even_raw = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_e_first", 70'(first_cyc - k), 70'd5);
    check("stall_e_last", 70'(last_cyc - k), 70'd6);
    @(posedge clk); #1;

    // Odd slot1 stalled: dual issue is blocked, slot0 goes alone and slot1 waits in SECOND.
    first_cyc = -1;
    stall_odd_raw = 1'b1;
    drive_pair(mk(0,3,1, 1,1, 0,0, 0,0, 210), mk(1,4,1, 5,1, 0,0, 0,0, 211), 1, 1, k, acc);
    @(negedge clk);
    @(negedge clk);
    check("stall_o_second_even_vld", 70'(even_src_vld), 70'd0);
    check("stall_o_second_odd_vld", 70'(odd_src_vld), 70'(3'b100));
    repeat (2) @(posedge clk);
    #1 stall_odd_raw = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_o_first", 70'(first_cyc - k), 70'd2);
    check("stall_o_last", 70'(last_cyc - k), 70'd5);
    @(posedge clk); #1;

    // Fill to DEPTH under a full stall; the extra pair must be refused.
    stall_even_raw = 1'b1;
    stall_odd_raw  = 1'b1;
    for (int p = 0; p < DEPTH + 1; p++) begin
      drive_pair(mk(0, 7'(p+1), 1, 8'(40+p),1, 0,0, 0,0, 11'(100+2*p)),
                 mk(1, 7'(p+20), 1, 8'(60+p),1, 0,0, 0,0, 11'(101+2*p)), 1, 1, k, acc);
      check($sformatf("full_in_ready_p%0d", p), 70'(acc), (p < DEPTH) ? 70'd1 : 70'd0);
    end
    check("full_count", 70'(count), 70'(DEPTH));
    check("full_in_ready_after", 70'(in_ready), 70'd0);
    stall_even_raw = 1'b0;
    stall_odd_raw  = 1'b0;
    wait_drain("full_drain");
    @(negedge clk);
    check("full_count_empty", 70'(count), 70'd0);
    @(posedge clk); #1;

    // Flush while the head sits in SECOND with three pairs queued.
    stall_odd_raw = 1'b1;
    p1a = mk(0,3,1, 1,1, 0,0, 0,0, 300);
    p1b = mk(1,4,1, 5,1, 0,0, 0,0, 301);
    drive_pair(p1a, p1b, 1, 1, k, acc);
    drive_pair(mk(0,5,1, 0,0, 0,0, 0,0, 302), mk(1,6,1, 0,0, 0,0, 0,0, 303), 1, 1, k, acc);
    drive_pair(mk(0,9,1, 0,0, 0,0, 0,0, 304), mk(1,10,1, 0,0, 0,0, 0,0, 305), 1, 1, k, acc);
    @(negedge clk);
    check("flush_pre_count", 70'(count), 70'd3);
    check("flush_pre_even_vld", 70'(even_src_vld), 70'd0);
    check("flush_pre_odd_vld", 70'(odd_src_vld), 70'(p1b[49:51]));
    branch_taken  = 1'b1;
    stall_odd_raw = 1'b0;
    in0_instr = mk(0,11,1, 0,0, 0,0, 0,0, 306);
    in1_instr = mk(1,12,1, 0,0, 0,0, 0,0, 307);
    in0_vld = 1'b1; in1_vld = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    in_valid = 1'b0; in0_vld = 1'b0; in1_vld = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_count", 70'(count), 70'd0);
    check("flush_no_issue", {68'd0, even_issue, odd_issue}, 70'd0);
    check("flush_in_ready", 70'(in_ready), 70'd1);
    @(posedge clk); #1;
    first_cyc = -1;
    drive_pair(mk(0,13,1, 1,1, 0,0, 0,0, 310), mk(1,14,1, 2,1, 0,0, 0,0, 311), 1, 1, k, acc);
    repeat (4) @(negedge clk);
    check("post_flush_first", 70'(first_cyc - k), 70'd2);
    check("post_flush_last", 70'(last_cyc - k), 70'd2);
    check("post_flush_count", 70'(count), 70'd0);
    wait_drain("post_flush_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
